// File: rtl/riscv_id_ex_pkg.sv
// rtl/riscv_id_ex_pkg.sv - shared RV32 decode constants and types
// Purpose: ALU operation codes, major opcodes, the decoded bundle type and
//          an immediate helper shared by riscv_decode and riscv_id_ex.
// Ports:   none (package).
package riscv_id_ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } id_bundle_t;

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/riscv_decode.sv
// rtl/riscv_decode.sv - combinational RV32 decode into ALU operands and op
// Purpose: maps instr/pc/register data to ALU x/y, op, rd, we and illegal.
// Ports:   instr, pc, rs1_data, rs2_data in (32 each);
//          x, y out (32); op out (4); rd out (5); we, illegal out (1).
module riscv_decode
  import riscv_id_ex_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [3:0]  op,
  output logic [4:0]  rd,
  output logic        we,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] shamt;
  logic        legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign shamt  = {27'b0, instr[24:20]};
  assign rd     = instr[11:7];

  always_comb begin
    legal = 1'b0;
    op    = ALU_ADD;
    x     = '0;
    y     = '0;
    case (opcode)
      OPC_OP: begin
        x     = rs1_data;
        y     = rs2_data;
        // funct7 0x20 only selects SUB and SRA.
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        case (f3)
          3'b000:  op = f7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = f7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        x     = rs1_data;
        y     = imm_i;
        legal = 1'b1;
        case (f3)
          3'b000:  op = ALU_ADD;
          3'b001: begin
            op    = ALU_SLL;
            y     = shamt;
            legal = (f7 == F7_BASE);
          end
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101: begin
            y = shamt;
            if (instr[30]) begin
              op    = ALU_SRA;
              legal = (f7 == F7_ALT);
            end else begin
              op    = ALU_SRL;
              legal = (f7 == F7_BASE);
            end
          end
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        y     = imm_u(instr);
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        x     = pc;
        y     = imm_u(instr);
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings travel on as a harmless ADD 0+0 so trap logic sees them.
    if (!legal) begin
      op = ALU_ADD;
      x  = '0;
      y  = '0;
    end
  end

  assign illegal = !legal;
  assign we      = legal && (rd != 5'd0);

endmodule

// File: rtl/riscv_id_ex.sv
// rtl/riscv_id_ex.sv - decode-to-execute valid/ready pipeline register
// Purpose: decodes the fetched instruction and holds the ALU bundle for execute,
//          with back-pressure, flush and optional writeback bypass.
// Macro:   RISCV_FWD_EN adds the wb_we/wb_rd/wb_data bypass ports.
// Ports:   clk, rst (sync, active-high), flush;
//          in_valid/in_ready, in_instr, in_pc, in_rs1_data, in_rs2_data;
//          wb_we, wb_rd, wb_data (RISCV_FWD_EN only);
//          out_valid/out_ready, out_x, out_y, out_op, out_rd, out_we, out_pc,
//          out_illegal.
module riscv_id_ex
  import riscv_id_ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
`ifdef RISCV_FWD_EN
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [3:0]  out_op,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;
  id_bundle_t  dec;
  id_bundle_t  bundle_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        load;

`ifdef RISCV_FWD_EN
  // Only register data is bypassed; decode alone decides whether x/y use it.
  assign rs1_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == in_instr[19:15])) ? wb_data : in_rs1_data;
  assign rs2_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == in_instr[24:20])) ? wb_data : in_rs2_data;
`else
  assign rs1_fwd = in_rs1_data;
  assign rs2_fwd = in_rs2_data;
`endif

  riscv_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rs1_fwd),
    .rs2_data (rs2_fwd),
    .x        (dec.x),
    .y        (dec.y),
    .op       (dec.op),
    .rd       (dec.rd),
    .we       (dec.we),
    .illegal  (dec.illegal)
  );

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q  <= 1'b1;
      bundle_q <= dec;
      pc_q     <= in_pc;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_x       = bundle_q.x;
  assign out_y       = bundle_q.y;
  assign out_op      = bundle_q.op;
  assign out_rd      = bundle_q.rd;
  assign out_we      = bundle_q.we;
  assign out_illegal = bundle_q.illegal;
  assign out_pc      = pc_q;

endmodule

// File: tb/tb_riscv_id_ex.sv
// tb/tb_riscv_id_ex.sv - scoreboard bench for riscv_id_ex
module tb_riscv_id_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
`ifdef RISCV_FWD_EN
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [31:0] out_pc;
  logic        out_illegal;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  riscv_id_ex dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
`ifdef RISCV_FWD_EN
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] pc, input logic [4:0] rd, input logic we,
                              input logic ill);
    exp_t e;
    e.op = op; e.x = x; e.y = y; e.pc = pc; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  // Compare every bundle execute consumes against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", {31'b0, out_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("op", {28'b0, out_op}, {28'b0, mon_e.op});
        check("x", out_x, mon_e.x);
        check("y", out_y, mon_e.y);
        check("pc", out_pc, mon_e.pc);
        check("rd", {27'b0, out_rd}, {27'b0, mon_e.rd});
        check("we", {31'b0, out_we}, {31'b0, mon_e.we});
        check("illegal", {31'b0, out_illegal}, {31'b0, mon_e.ill});
      end
    end
  end

  // Present one instruction and hold it until the stage accepts it.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                      input logic [31:0] rs2, input exp_t e, input bit push);
    bit done = 1'b0;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    in_valid    = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
`ifdef RISCV_FWD_EN
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_x", out_x, 32'd0);
    check("rst_y", out_y, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_op", {28'b0, out_op}, 32'd0);
    check("rst_rd", {27'b0, out_rd}, 32'd0);
    check("rst_we", {31'b0, out_we}, 32'd0);
    check("rst_ill", {31'b0, out_illegal}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream with execute always ready.
    send(32'h002081B3, 32'h0,   32'd5,        32'd7, mk(4'd0, 32'd5, 32'd7, 32'h0, 5'd3, 1'b1, 1'b0), 1);
    send(32'h40435293, 32'h4,   32'h80000000, 32'd0, mk(4'd7, 32'h80000000, 32'd4, 32'h4, 5'd5, 1'b1, 1'b0), 1);
    send(32'h12345097, 32'h100, 32'd77,       32'd0, mk(4'd0, 32'h100, 32'h12345000, 32'h100, 5'd1, 1'b1, 1'b0), 1);
    send(32'h40208233, 32'h104, 32'd10,       32'd3, mk(4'd1, 32'd10, 32'd3, 32'h104, 5'd4, 1'b1, 1'b0), 1);
    send(32'hFFF00313, 32'h108, 32'd0,        32'd0, mk(4'd0, 32'd0, 32'hFFFFFFFF, 32'h108, 5'd6, 1'b1, 1'b0), 1);
    send(32'hABCDE037, 32'h10C, 32'd9,        32'd9, mk(4'd0, 32'd0, 32'hABCDE000, 32'h10C, 5'd0, 1'b0, 1'b0), 1);
    send(32'h0000027F, 32'h110, 32'd1,        32'd2, mk(4'd0, 32'd0, 32'd0, 32'h110, 5'd4, 1'b0, 1'b1), 1);
    send(32'h40209233, 32'h114, 32'd1,        32'd2, mk(4'd0, 32'd0, 32'd0, 32'h114, 5'd4, 1'b0, 1'b1), 1);
    send(32'h40009093, 32'h118, 32'd1,        32'd2, mk(4'd0, 32'd0, 32'd0, 32'h118, 5'd1, 1'b0, 1'b1), 1);
    send(32'h0051B113, 32'h11C, 32'd9,        32'd0, mk(4'd4, 32'd9, 32'd5, 32'h11C, 5'd2, 1'b1, 1'b0), 1);
    idle(2);

    // Stall: held bundle stable, then the waiting instruction loads with no bubble.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h200, 32'd1, 32'd2, mk(4'd0, 32'd1, 32'd2, 32'h200, 5'd3, 1'b1, 1'b0), 1);
    in_instr = 32'h0051B113; in_pc = 32'h204; in_rs1_data = 32'd9; in_rs2_data = 32'd0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_x", out_x, 32'd1);
      check("stall_pc", out_pc, 32'h200);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    sb.push_back(mk(4'd4, 32'd9, 32'd5, 32'h204, 5'd2, 1'b1, 1'b0));
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("nobubble_valid", {31'b0, out_valid}, 32'd1);
    check("nobubble_x", out_x, 32'd9);
    @(posedge clk);
    #1;

    // Flush a held bundle while fetch waits, then flush an incoming load.
    out_ready = 1'b0;
    send(32'h12345097, 32'h300, 32'd0, 32'd0, mk(4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0), 0);
    in_instr = 32'h0000027F; in_pc = 32'h304; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_held_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("flush_held_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_drop_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Reset while stalled clears the bundle.
    send(32'h002081B3, 32'h400, 32'd5, 32'd7, mk(4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0), 0);
    in_instr = 32'h0051B113; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rststall_valid", {31'b0, out_valid}, 32'd0);
    check("rststall_x", out_x, 32'd0);
    check("rststall_we", {31'b0, out_we}, 32'd0);
    check("rststall_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

`ifdef RISCV_FWD_EN
    wb_we = 1'b1; wb_data = 32'hDEAD;
    wb_rd = 5'd4;
    send(32'h005201B3, 32'h500, 32'd1, 32'd2, mk(4'd0, 32'hDEAD, 32'd2, 32'h500, 5'd3, 1'b1, 1'b0), 1);
    wb_rd = 5'd5;
    send(32'h005201B3, 32'h504, 32'd1, 32'd2, mk(4'd0, 32'd1, 32'hDEAD, 32'h504, 5'd3, 1'b1, 1'b0), 1);
    wb_rd = 5'd0;
    send(32'h005001B3, 32'h508, 32'd1, 32'd2, mk(4'd0, 32'd1, 32'd2, 32'h508, 5'd3, 1'b1, 1'b0), 1);
    wb_rd = 5'd27;
    send(32'hABCDE037, 32'h50C, 32'd1, 32'd2, mk(4'd0, 32'd0, 32'hABCDE000, 32'h50C, 5'd0, 1'b0, 1'b0), 1);
    wb_we = 1'b0;
`else
    send(32'h005201B3, 32'h500, 32'd1, 32'd2, mk(4'd0, 32'd1, 32'd2, 32'h500, 5'd3, 1'b1, 1'b0), 1);
`endif
    idle(3);

    check("sb_left", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_id_ex.md
# riscv_id_ex

Decode-to-execute pipeline stage of the RISC-V core. Takes a fetched instruction and its register-file read data, decodes it into a 4-bit ALU operation code and two 32-bit ALU operands, and holds them in a valid/ready pipeline register that feeds `riscv_alu` directly. Supports back-pressure from execute, flush from branch resolution, and optional writeback bypass.

## Interface
- No parameters; all widths are fixed to RV32.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard held and incoming instruction this cycle.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: instruction address.
- `in_rs1_data`, `in_rs2_data` in 32 each: register-file read data for `instr[19:15]` and `instr[24:20]`.
- `wb_we` in 1, `wb_rd` in 5, `wb_data` in 32: writeback bypass; present only with `RISCV_FWD_EN`.
- `out_valid` out 1: decoded bundle is valid.
- `out_ready` in 1: execute consumes the bundle.
- `out_x`, `out_y` out 32: ALU operands.
- `out_op` out 4: ALU operation code.
- `out_rd` out 5, `out_we` out 1: destination register and write enable.
- `out_pc` out 32: PC of the held instruction.
- `out_illegal` out 1: unsupported encoding.

## Operation
- Decode classes:
  - OP (0110011): x=rs1, y=rs2.
    - funct3 maps 000 ADD/SUB (funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (funct7[5]), 110 OR, 111 AND.
    - funct7 other than 0x00/0x20, or 0x20 with funct3 not in {000,101}, is illegal.
  - OP-IMM (0010011): x=rs1, y=sign-extended instr[31:20]; no SUBI.
    - Shifts: y = zero-extended instr[24:20].
    - SRAI when instr[30]=1.
    - SLLI/SRLI with instr[31:25] not 0x00 (0x20 for SRAI) is illegal.
  - LUI (0110111): x=0, y={instr[31:12],12'b0}, op ADD.
  - AUIPC (0010111): x=pc, y={instr[31:12],12'b0}, op ADD.
  - Any other opcode is illegal.
- Illegal instructions: out_illegal=1, out_we=0, op ADD, x=y=0. They still propagate as valid so the trap logic sees them.
- out_we = legal && rd!=0.
- Handshake: in_ready = !out_valid || out_ready. The register loads when in_valid && in_ready.
- The held bundle is stable while out_valid && !out_ready.
- flush: next-cycle out_valid=0. Incoming instruction in the same cycle is dropped. in_ready remains per the formula.

## Timing
- Latency 1 cycle: accepted at edge N, visible on outputs after edge N.
- Full throughput: one instruction per cycle when out_ready is held high.
- Reset values: out_valid=0, out_x/out_y/out_pc=0, out_op=ADD (4'd0), out_rd=0, out_we=0, out_illegal=0.
- Reset asserted mid-stall clears the bundle. in_ready=1 the cycle after reset.
- flush and rst outrank load. Load outranks hold.
- Simultaneous consume and load: the new bundle replaces the old one with no bubble.

## Configuration
- `RISCV_FWD_EN` defined:
  - The wb_* ports exist.
  - At capture, rs1 (and rs2 for OP) is replaced by wb_data when wb_we && wb_rd!=0 && wb_rd equals that source field.
  - The bypass applies only to register operands, never to imm/pc operands.
- `RISCV_FWD_EN` undefined: wb_* ports are absent and operands come from the register file unmodified.

## Structure
- ALU opcode constants belong in the shared global parameters: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- Opcode constants (OP, OP_IMM, LUI, AUIPC) also belong there.
- One combinational sub-module, `riscv_decode`, maps instr/pc/rs data to the bundle and the illegal flag. `riscv_id_ex` owns the register, handshake and bypass.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op=ADD, x=5, y=7, rd=3, we=1.
- `srai x5,x6,4` (0x40435293), rs1=0x80000000 -> op=SRA, y=4, illegal=0.
- `auipc x1,0x12345` at pc=0x100 -> x=0x100, y=0x12345000, op=ADD.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and the bundle is unchanged. out_ready=1 -> the next instruction loads with no bubble.
- flush with a held bundle and in_valid=1 -> out_valid=0 next cycle. Opcode 0x7F -> illegal=1, we=0.
- With `RISCV_FWD_EN`: rs1 field=4, wb_we=1, wb_rd=4, wb_data=0xDEAD -> x=0xDEAD. With wb_rd=0 -> no bypass.
